// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e       - receiver FSM state encoding
//   DEFAULT_OVERSAMPLE - rx_tick pulses per bit period
//   DATA_BITS          - data bits per frame
//   parity_bit()       - parity bit that accompanies a data byte
package uart_pkg;

   localparam int DEFAULT_OVERSAMPLE = 16;
   localparam int DATA_BITS          = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_state_e;

   // Returns the parity bit for d: even parity makes the total count of
   // ones (data + parity) even; odd parity makes it odd.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                       input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and byte-side signals of the UART receiver.
//   rx_tick       - one-clk enable at OVERSAMPLE x baud
//   rx_data_in    - asynchronous serial line, idles high
//   rx_data_out   - last received byte
//   rx_valid      - one-clk strobe when a frame completes
//   rx_parity_err - parity mismatch in the last frame
//   rx_frame_err  - stop bit sampled low in the last frame
//   rx_busy       - frame in progress
//   dbg_state     - receiver FSM state, for observation only
// Handshake: rx_valid is a single-cycle strobe with no ready. The receiver
// cannot be stalled; rx_data_out and both error flags stay stable from the
// rx_valid cycle until the next frame completes, so the consumer may capture
// them on the strobe or at any time before the next one.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 rx_tick;
   logic                 rx_data_in;
   logic [DATA_BITS-1:0] rx_data_out;
   logic                 rx_valid;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_busy;
   uart_state_e          dbg_state;

   modport slave (
      input  rx_tick, rx_data_in,
      output rx_data_out, rx_valid, rx_parity_err, rx_frame_err, rx_busy,
             dbg_state
   );

   modport master (
      output rx_tick, rx_data_in,
      input  rx_data_out, rx_valid, rx_parity_err, rx_frame_err, rx_busy,
             dbg_state
   );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the asynchronous serial line.
//   clk   - system clock
//   reset - synchronous active-high reset; both flops reset to 1 (line idle)
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] ff;

   always_ff @(posedge clk) begin
      if (reset) ff <= 2'b11;
      else       ff <= {ff[0], d};
   end

   assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 1 start, 8 data LSB-first, optional
// parity, 1 stop bit.
//   clk   - system clock
//   reset - synchronous active-high reset, dominates rx_tick
//   bus   - uart_rx_if.slave: rx_tick / rx_data_in in; byte, strobe, error
//           flags, busy and FSM state out
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   uart_rx_if.slave    bus
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   // START samples mid start bit; every later bit is one full period on.
   localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   logic                 line;
   uart_state_e          state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 perr, perr_nxt;
   logic                 done;

   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 perr_q;
   logic                 ferr_q;

   uart_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.rx_data_in),
      .q     (line)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         perr    <= perr_nxt;
         // done is only raised on a tick edge, so the strobe is one clk wide
         // whatever the tick spacing.
         valid_q <= done;
         if (done) begin
            data_q <= shreg;
            perr_q <= PARITY_EN && perr;
            ferr_q <= ~line;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      perr_nxt  = perr;
      done      = 1'b0;
      if (bus.rx_tick) begin
         unique case (state)
            IDLE: begin
               if (!line) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
                  perr_nxt  = 1'b0;
               end
            end
            START: begin
               if (cnt == HALF_CNT) begin
                  cnt_nxt   = '0;
                  // A line that is high again mid start bit was a glitch.
                  state_nxt = line ? IDLE : DATA;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == FULL_CNT) begin
                  cnt_nxt        = '0;
                  shreg_nxt[idx] = line;
                  idx_nxt        = idx + IW'(1);
                  if (idx == LAST_IDX) state_nxt = PARITY_EN ? PARITY : STOP;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            PARITY: begin
               if (cnt == FULL_CNT) begin
                  cnt_nxt   = '0;
                  perr_nxt  = (line != parity_bit(shreg, PARITY_ODD));
                  state_nxt = STOP;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == FULL_CNT) begin
                  cnt_nxt   = '0;
                  done      = 1'b1;
                  // A low stop bit may be a break; wait for the line to
                  // return high so the break is not taken as a new start.
                  state_nxt = line ? IDLE : WAIT_HIGH;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (line) state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.rx_data_out   = data_q;
   assign bus.rx_valid      = valid_q;
   assign bus.rx_parity_err = perr_q;
   assign bus.rx_frame_err  = ferr_q;
   assign bus.rx_busy       = (state == START) || (state == DATA) ||
                              (state == PARITY) || (state == STOP);
   assign bus.dbg_state     = state;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, 16, rx_tick pulses per bit period.
REQ-002 Parameter PARITY_EN, 1, a parity bit follows the data bits when 1 and is omitted when 0.
REQ-003 Parameter PARITY_ODD, 0, parity is odd when 1 and even when 0.
REQ-004 clk  input  1  system clock; one clock for the whole block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_tick  input  1  one-clk-wide enable at OVERSAMPLE x baud, driven by brg rxclk.
REQ-007 rx_data_in  input  1  asynchronous serial line; idles high.
REQ-008 rx_data_out  output  8  last received byte.
REQ-009 rx_valid  output  1  one-clk pulse when a frame completes.
REQ-010 rx_parity_err  output  1  parity mismatch in the last frame.
REQ-011 rx_frame_err  output  1  stop bit sampled low in the last frame.
REQ-012 rx_busy  output  1  high while a frame is in progress.

Function
REQ-013 rx_data_in shall pass through a 2-FF synchronizer clocked every clk; all sampling shall use the synchronized value.
REQ-014 The frame shall be 1 start bit (low), then 8 data bits LSB-first, then an optional parity bit, then 1 stop bit (high): 11 bits with parity, 10 without.
REQ-015 State and counter updates shall occur only on clk edges with rx_tick=1, except rx_valid deassertion and synchronizer shifting.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, and WAIT_HIGH.
REQ-017 IDLE: on a tick with the line low, go to START and clear the tick counter to 0.
REQ-018 START: at counter = OVERSAMPLE/2-1, go to DATA with counter 0 if the line is low; otherwise treat it as a glitch and return to IDLE with no flags changed.
REQ-019 DATA: at counter = OVERSAMPLE-1, shift the sample into bit index 0..7 and clear the counter; after index 7, go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: at counter = OVERSAMPLE-1, compare the sample with the computed parity of the 8 data bits, latch the mismatch, and go to STOP.
REQ-021 STOP: at counter = OVERSAMPLE-1, on the same edge:
- load rx_data_out from the shift register;
- update rx_parity_err (0 when PARITY_EN=0);
- set rx_frame_err to the inverse of the sample;
- assert rx_valid.
REQ-022 After STOP, the next state shall be IDLE if the stop sample is high and WAIT_HIGH if it is low.
REQ-023 WAIT_HIGH: remain until a tick sees the line high, then go to IDLE, so that a break does not retrigger the receiver.
REQ-024 rx_valid shall be high for exactly one clk cycle per completed frame, regardless of the rx_tick spacing.
REQ-025 The byte shall be delivered even when rx_frame_err or rx_parity_err is set.
REQ-026 rx_data_out, rx_parity_err and rx_frame_err shall hold until the next frame completes.
REQ-027 rx_busy shall be high in START, DATA, PARITY and STOP, and low in IDLE and WAIT_HIGH.
REQ-028 A line low at the tick immediately after the STOP sample shall be accepted as the next start bit (back-to-back frames).
REQ-029 The tick counter width shall be clog2(OVERSAMPLE), and the counter shall clear on every state change.

Reset
REQ-030 Reset shall force:
- state to IDLE and the counter and bit index to 0;
- rx_data_out to 8'h00;
- rx_valid, rx_parity_err, rx_frame_err and rx_busy to 0;
- both synchronizer flops to 1.
REQ-031 Reset mid-frame shall abort the frame with no rx_valid; reset shall take precedence over rx_tick.

Structure
REQ-032 Shared package uart_pkg shall hold the state encoding, the default OVERSAMPLE, the frame constants (DATA_BITS=8) and the parity function, all shared with uart_tx.
REQ-033 The synchronizer shall be a separate sub-module, uart_sync, with a 2-stage reset value of 1.

Verification
REQ-034 Clean frame: with PARITY_EN=1 and even parity, send 8'hAD with parity bit 1 -> one rx_valid pulse, rx_data_out=8'hAD, both errors 0.
REQ-035 Back-to-back frames: send 8'hE3 then 8'hB2 with no idle gap -> two rx_valid pulses, 8'hE3 then 8'hB2, both errors 0.
REQ-036 Parity error: send 8'hB2 with parity bit 1 -> rx_data_out=8'hB2, rx_parity_err=1, rx_valid pulses.
REQ-037 Framing error and break: send 8'h55 with stop bit 0, then hold the line low for 3 bit periods -> rx_frame_err=1, one rx_valid only, rx_busy=0 until the line rises, then the next frame is received correctly.
REQ-038 Glitch rejection: drive a low pulse of 4 ticks -> return to IDLE, no rx_valid, flags unchanged.
REQ-039 Reset mid-frame: assert reset at data bit 4 of 8'hAD -> all outputs 0, no rx_valid; the following 8'hE3 is received correctly.
